apu_offload_ctrl: RTL and testbench
===================================

# apu_offload_ctrl

Core-side initiator for the vector accelerator's APU offload port. It accepts offloaded vector instructions from the CPU pipeline into a small in-order queue and drives them onto the `apu_req`/`apu_gnt` request channel, one at a time. It waits for `apu_rvalid` when the instruction returns a scalar, and pauses issue while the accelerator holds the core for a VLSU access. It sits between the CPU offload stage and `accelerator_top`, which is the responder on this protocol.

## Interface
- `X_ID_WIDTH`, default 4, instruction ID width; must match the accelerator.
- `FIFO_DEPTH`, default 4, queue entries; power of two, ≥2.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid_i` in 1: CPU offers an instruction.
- `req_ready_o` out 1: queue can accept; equals `!full && !reset`.
- `req_op_i` in 6: APU opcode.
- `req_flags_i` in 15: APU flags.
- `req_operands_i` in 3×32: scalar operands.
- `req_id_i` in `X_ID_WIDTH`: instruction ID.
- `req_wb_i` in 1: instruction returns a scalar result.
- `apu_req_o` out 1: request to accelerator.
- `apu_gnt_i` in 1: accelerator accepts.
- `apu_op_o` out 6: head-entry payload.
- `apu_flags_o` out 15: head-entry payload.
- `apu_operands_o` out 3×32: head-entry payload.
- `offloaded_id_o` out `X_ID_WIDTH`: head-entry payload.
- `apu_rvalid_i` in 1: result valid.
- `apu_result_i` in 32: result data.
- `instruction_id_i` in `X_ID_WIDTH`: ID of the returned result.
- `core_halt_i` in 1: accelerator VLSU owns memory.
- `vlsu_done_i` in 1: VLSU transfer finished.
- `rsp_valid_o` out 1: result pulse to CPU.
- `rsp_result_o` out 32: result data to CPU.
- `rsp_id_o` out `X_ID_WIDTH`: ID of the result sent to CPU.
- `busy_o` out 1: queue non-empty or state ≠ IDLE.
- `id_err_o` out 1: sticky ID-mismatch flag.

## Operation
- **Queue.** A push occurs on `req_valid_i && req_ready_o`. Each entry holds {op, flags, operands, id, wb}. The entry is popped on `apu_req_o && apu_gnt_i`.
- **FSM states:** IDLE, ISSUE, WAIT_RSP, HALT.
- **IDLE:**
  - Queue non-empty and `core_halt_i` high → HALT.
  - Queue non-empty and `core_halt_i` low → ISSUE.
- **HALT:** on `vlsu_done_i` or `!core_halt_i` → IDLE.
- **ISSUE:**
  - `apu_req_o`=1. The payload is the queue head and is held stable until grant.
  - `core_halt_i` is ignored while the request is pending; the request is never withdrawn.
  - On grant with head wb=1: latch the ID, go to WAIT_RSP.
  - On grant with head wb=0: go to IDLE.
- **WAIT_RSP:** on `apu_rvalid_i`, register result and ID into `rsp_*`, pulse `rsp_valid_o`, go to IDLE.
- **Stray `apu_rvalid_i`:** ignored outside WAIT_RSP.
- **Outstanding limit:** at most one instruction is outstanding. Pushes continue during ISSUE, WAIT_RSP and HALT.
- **Full queue:** `req_ready_o`=0. A pop and a push may occur in the same cycle only when the queue is not full at the start of the cycle.
- **Reset mid-operation:**
  - Queue flushed, state set to IDLE.
  - `apu_req_o` drops at the reset edge, even if ungranted.
  - Any pending response is discarded.

## Timing
- **Output reset values:**
  - `apu_req_o`, `rsp_valid_o`, `busy_o`, `id_err_o` = 0.
  - `rsp_result_o`, `rsp_id_o` = 0.
  - Payload outputs = 0 while the queue is empty.
  - `req_ready_o` = 0 during reset and 1 in the first cycle after it.
- **Accept to request:** push in cycle T → IDLE sees the entry in T+1 → `apu_req_o` high in T+2.
- **Back-to-back, no wb:** grant in cycle G → IDLE in G+1 → next request in G+2, a one-cycle bubble.
- **Result to CPU:** `apu_rvalid_i` in cycle R → `rsp_valid_o` high for exactly cycle R+1.
- **Grant and rvalid in the same cycle:** rvalid is ignored, because the FSM is not yet in WAIT_RSP. The accelerator guarantees rvalid ≥1 cycle after grant.

## Configuration
- **`APU_OFFLOAD_ID_CHECK_EN` defined:**
  - In WAIT_RSP, `instruction_id_i` is compared against the latched ID.
  - A mismatch sets `id_err_o`, which stays set until reset.
  - The response is still forwarded to the CPU.
- **Not defined:** no comparator is built and `id_err_o` is tied to 0.

## Structure
- **`accelerator_pkg` additions:**
  - `apu_offload_state_t`: enum with the four states.
  - `apu_offload_entry_t`: packed struct matching the queue entry.
- **Sub-module `apu_offload_fifo`:**
  - Synchronous FIFO of `apu_offload_entry_t`, parameter `FIFO_DEPTH`.
  - Ports: push, pop, head, full, empty, flush on reset.
  - Built with wrap-around pointers plus a count.

## Test plan
- **Single no-wb op:** push op=6'h01, id=3 at T → `apu_req_o` high at T+2. Grant at T+4 → `apu_req_o` low at T+5, `busy_o` low at T+5, no `rsp_valid_o`.
- **wb op (vsetvl):** push wb=1, id=5; grant; rvalid=1 with result=32'h10, instruction_id=5, two cycles later → `rsp_valid_o` one cycle, `rsp_result_o`=32'h10, `rsp_id_o`=5, `id_err_o`=0.
- **Full queue:** hold `apu_gnt_i`=0, push 4 entries → `req_ready_o`=0. Grant → ready=1 the next cycle, and entries issue in order with ids 0,1,2,3.
- **Halt:** `core_halt_i`=1 with the queue non-empty in IDLE → no `apu_req_o` until `vlsu_done_i` pulses. Request appears 2 cycles after the pulse.
- **Reset mid-request:** assert `reset` while `apu_req_o`=1 with 2 entries queued → next cycle `apu_req_o`=0, `busy_o`=0, and the queue is empty (no further requests).
- **ID check (macro on):** expect id=2, return `instruction_id_i`=7 → `id_err_o`=1 and stays 1. `rsp_valid_o` still pulses.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared accelerator types: APU offload FSM states and the offload queue entry.
package accelerator_pkg;

    // Instruction ID width shared by the core and accelerator_top
    localparam int APU_X_ID_WIDTH = 4;
    localparam int APU_OP_WIDTH    = 6;
    localparam int APU_FLAGS_WIDTH = 15;
    localparam int APU_NUM_ARGS    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_HALT
    } apu_offload_state_t;

    typedef struct packed {
        logic [APU_OP_WIDTH-1:0]          op;
        logic [APU_FLAGS_WIDTH-1:0]       flags;
        logic [APU_NUM_ARGS-1:0][31:0]    operands;
        logic [APU_X_ID_WIDTH-1:0]        id;
        logic                             wb;
    } apu_offload_entry_t;

endpackage

// File: rtl/apu_offload_fifo.sv
// In-order queue of APU offload entries; wrap-around pointers plus an occupancy count.
module apu_offload_fifo
    import accelerator_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  apu_offload_entry_t wdata,
    output apu_offload_entry_t head,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    apu_offload_entry_t mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_en;
    logic               pop_en;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the count alone decides validity, so a flush costs nothing here.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wdata;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/apu_offload_ctrl.sv
// Core-side APU offload initiator: queues CPU offloads and issues them one at a time.
// Optional build macro APU_OFFLOAD_ID_CHECK_EN adds a sticky returned-ID mismatch flag.
module apu_offload_ctrl
    import accelerator_pkg::*;
#(
    parameter int X_ID_WIDTH = APU_X_ID_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [5:0]            req_op_i,
    input  logic [14:0]           req_flags_i,
    input  logic [2:0][31:0]      req_operands_i,
    input  logic [X_ID_WIDTH-1:0] req_id_i,
    input  logic                  req_wb_i,
    output logic                  apu_req_o,
    input  logic                  apu_gnt_i,
    output logic [5:0]            apu_op_o,
    output logic [14:0]           apu_flags_o,
    output logic [2:0][31:0]      apu_operands_o,
    output logic [X_ID_WIDTH-1:0] offloaded_id_o,
    input  logic                  apu_rvalid_i,
    input  logic [31:0]           apu_result_i,
    input  logic [X_ID_WIDTH-1:0] instruction_id_i,
    input  logic                  core_halt_i,
    input  logic                  vlsu_done_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_result_o,
    output logic [X_ID_WIDTH-1:0] rsp_id_o,
    output logic                  busy_o,
    output logic                  id_err_o
);

    apu_offload_state_t state, state_next;
    apu_offload_entry_t wdata, head;
    logic               fifo_full, fifo_empty;
    logic               grant, rsp_fire;

    always_comb begin
        wdata          = '0;
        wdata.op       = req_op_i;
        wdata.flags    = req_flags_i;
        wdata.operands = req_operands_i;
        wdata.id       = APU_X_ID_WIDTH'(req_id_i);
        wdata.wb       = req_wb_i;
    end

    apu_offload_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid_i && req_ready_o),
        .pop   (grant),
        .wdata (wdata),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready_o    = !fifo_full && !reset;
    assign busy_o         = !fifo_empty || (state != ST_IDLE);
    assign apu_op_o       = head.op;
    assign apu_flags_o    = head.flags;
    assign apu_operands_o = head.operands;
    assign offloaded_id_o = X_ID_WIDTH'(head.id);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (!fifo_empty) state_next = core_halt_i ? ST_HALT : ST_ISSUE;
            // The request is never withdrawn once raised, so halt is not looked at here
            ST_ISSUE:    if (apu_gnt_i) state_next = head.wb ? ST_WAIT_RSP : ST_IDLE;
            ST_WAIT_RSP: if (apu_rvalid_i) state_next = ST_IDLE;
            ST_HALT:     if (vlsu_done_i || !core_halt_i) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        apu_req_o = (state == ST_ISSUE);
        grant     = apu_req_o && apu_gnt_i;
        rsp_fire  = (state == ST_WAIT_RSP) && apu_rvalid_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_id_o     <= '0;
        end else begin
            rsp_valid_o <= rsp_fire;
            if (rsp_fire) begin
                rsp_result_o <= apu_result_i;
                rsp_id_o     <= instruction_id_i;
            end
        end
    end

`ifdef APU_OFFLOAD_ID_CHECK_EN
    logic [X_ID_WIDTH-1:0] expected_id;
    logic                  id_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            expected_id <= '0;
            id_err      <= 1'b0;
        end else begin
            if (grant && head.wb) expected_id <= offloaded_id_o;
            if (rsp_fire && (instruction_id_i != expected_id)) id_err <= 1'b1;
        end
    end

    assign id_err_o = id_err;
`else
    assign id_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_apu_offload_ctrl.sv
// Directed bench for apu_offload_ctrl: issue timing, wb responses, full queue, halt, reset, ID check.
module tb_apu_offload_ctrl;

`ifdef APU_OFFLOAD_ID_CHECK_EN
    localparam logic ID_CHK = 1'b1;
`else
    localparam logic ID_CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [5:0]      req_op_i;
    logic [14:0]     req_flags_i;
    logic [2:0][31:0] req_operands_i;
    logic [3:0]      req_id_i;
    logic            req_wb_i;
    logic            apu_req_o;
    logic            apu_gnt_i;
    logic [5:0]      apu_op_o;
    logic [14:0]     apu_flags_o;
    logic [2:0][31:0] apu_operands_o;
    logic [3:0]      offloaded_id_o;
    logic            apu_rvalid_i;
    logic [31:0]     apu_result_i;
    logic [3:0]      instruction_id_i;
    logic            core_halt_i;
    logic            vlsu_done_i;
    logic            rsp_valid_o;
    logic [31:0]     rsp_result_o;
    logic [3:0]      rsp_id_o;
    logic            busy_o;
    logic            id_err_o;

    int checks = 0;
    int errors = 0;

    apu_offload_ctrl #(.X_ID_WIDTH(4), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_op_i         (req_op_i),
        .req_flags_i      (req_flags_i),
        .req_operands_i   (req_operands_i),
        .req_id_i         (req_id_i),
        .req_wb_i         (req_wb_i),
        .apu_req_o        (apu_req_o),
        .apu_gnt_i        (apu_gnt_i),
        .apu_op_o         (apu_op_o),
        .apu_flags_o      (apu_flags_o),
        .apu_operands_o   (apu_operands_o),
        .offloaded_id_o   (offloaded_id_o),
        .apu_rvalid_i     (apu_rvalid_i),
        .apu_result_i     (apu_result_i),
        .instruction_id_i (instruction_id_i),
        .core_halt_i      (core_halt_i),
        .vlsu_done_i      (vlsu_done_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_result_o     (rsp_result_o),
        .rsp_id_o         (rsp_id_o),
        .busy_o           (busy_o),
        .id_err_o         (id_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] op, input logic [3:0] id, input logic wb);
        req_valid_i    = 1'b1;
        req_op_i       = op;
        req_flags_i    = {11'h0, id};
        req_operands_i = {28'h0, id, 32'hB0, 32'hA0};
        req_id_i       = id;
        req_wb_i       = wb;
        tick();
        req_valid_i    = 1'b0;
    endtask

    task automatic issue_and_check(input logic [3:0] exp_id);
        int n = 0;
        while (!apu_req_o && n < 10) begin
            tick();
            n++;
        end
        check("issue_req", apu_req_o, 1'b1);
        check("issue_id", offloaded_id_o, exp_id);
        apu_gnt_i = 1'b1;
        tick();
        apu_gnt_i = 1'b0;
    endtask

    initial begin
        logic seen;
        int   n;

        reset = 1'b1; req_valid_i = 0; req_op_i = 0; req_flags_i = 0; req_operands_i = '0;
        req_id_i = 0; req_wb_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0; apu_result_i = 0;
        instruction_id_i = 0; core_halt_i = 0; vlsu_done_i = 0;

        repeat (3) tick();
        check("rst_req", apu_req_o, 1'b0);
        check("rst_ready", req_ready_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_id_err", id_err_o, 1'b0);
        check("rst_rsp_result", rsp_result_o, 32'h0);
        check("rst_rsp_id", rsp_id_o, 4'h0);
        check("rst_op", apu_op_o, 6'h0);
        check("rst_offl_id", offloaded_id_o, 4'h0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", req_ready_o, 1'b1);

        // Single no-wb op: request at T+2, grant at T+4, idle at T+5
        push(6'h01, 4'd3, 1'b0);
        check("t1_req_T1", apu_req_o, 1'b0);
        check("t1_busy_T1", busy_o, 1'b1);
        tick();
        check("t1_req_T2", apu_req_o, 1'b1);
        check("t1_op", apu_op_o, 6'h01);
        check("t1_id", offloaded_id_o, 4'd3);
        check("t1_flags", apu_flags_o, 15'h3);
        check("t1_operands", apu_operands_o, {32'h3, 32'hB0, 32'hA0});
        tick();
        check("t1_req_T3", apu_req_o, 1'b1);
        tick();
        apu_gnt_i = 1'b1;
        tick();
        apu_gnt_i = 1'b0;
        check("t1_req_T5", apu_req_o, 1'b0);
        check("t1_busy_T5", busy_o, 1'b0);
        check("t1_rsp_T5", rsp_valid_o, 1'b0);
        tick();
        check("t1_rsp_T6", rsp_valid_o, 1'b0);

        // wb op: grant, result two cycles later, one-cycle response pulse
        push(6'h2A, 4'd5, 1'b1);
        tick();
        check("t2_req", apu_req_o, 1'b1);
        apu_gnt_i = 1'b1;
        tick();
        apu_gnt_i = 1'b0;
        check("t2_req_after_gnt", apu_req_o, 1'b0);
        check("t2_busy_wait", busy_o, 1'b1);
        tick();
        apu_rvalid_i = 1'b1; apu_result_i = 32'h10; instruction_id_i = 4'd5;
        tick();
        apu_rvalid_i = 1'b0;
        check("t2_rsp_valid", rsp_valid_o, 1'b1);
        check("t2_rsp_result", rsp_result_o, 32'h10);
        check("t2_rsp_id", rsp_id_o, 4'd5);
        check("t2_id_err", id_err_o, 1'b0);
        tick();
        check("t2_rsp_pulse_end", rsp_valid_o, 1'b0);
        check("t2_busy_end", busy_o, 1'b0);

        // Stray rvalid in IDLE is ignored
        apu_rvalid_i = 1'b1; apu_result_i = 32'h55; instruction_id_i = 4'd1;
        tick();
        apu_rvalid_i = 1'b0;
        check("stray_rsp_valid", rsp_valid_o, 1'b0);
        check("stray_rsp_result", rsp_result_o, 32'h10);

        // Full queue: four pushes with no grant, a refused fifth, then in-order drain
        for (int i = 0; i < 4; i++) push(6'h03, 4'(i), 1'b0);
        check("full_ready", req_ready_o, 1'b0);
        req_valid_i = 1'b1; req_id_i = 4'd9; req_wb_i = 1'b0;
        tick();
        check("full_ready_hold", req_ready_o, 1'b0);
        check("full_req", apu_req_o, 1'b1);
        check("full_head_id", offloaded_id_o, 4'd0);
        apu_gnt_i = 1'b1;
        tick();
        apu_gnt_i = 1'b0;
        req_valid_i = 1'b0;
        check("full_ready_after_gnt", req_ready_o, 1'b1);
        for (int i = 1; i < 4; i++) issue_and_check(4'(i));
        check("full_drained_busy", busy_o, 1'b0);

        // Halt in IDLE blocks issue until vlsu_done; request 2 cycles after the pulse
        core_halt_i = 1'b1;
        push(6'h04, 4'd4, 1'b0);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen |= apu_req_o;
        end
        check("halt_no_req", seen, 1'b0);
        check("halt_busy", busy_o, 1'b1);
        vlsu_done_i = 1'b1; core_halt_i = 1'b0;
        tick();
        vlsu_done_i = 1'b0;
        check("halt_req_P1", apu_req_o, 1'b0);
        tick();
        check("halt_req_P2", apu_req_o, 1'b1);
        core_halt_i = 1'b1;
        tick();
        check("halt_ignored_in_issue", apu_req_o, 1'b1);
        check("halt_issue_id", offloaded_id_o, 4'd4);
        core_halt_i = 1'b0;
        apu_gnt_i = 1'b1;
        tick();
        apu_gnt_i = 1'b0;
        check("halt_done_busy", busy_o, 1'b0);

        // Reset while a request is pending with a second entry queued
        push(6'h05, 4'd6, 1'b0);
        push(6'h05, 4'd7, 1'b0);
        n = 0;
        while (!apu_req_o && n < 10) begin
            tick();
            n++;
        end
        check("rmid_req_before", apu_req_o, 1'b1);
        reset = 1'b1;
        #1;
        check("rmid_ready_in_rst", req_ready_o, 1'b0);
        tick();
        check("rmid_req_dropped", apu_req_o, 1'b0);
        check("rmid_busy", busy_o, 1'b0);
        reset = 1'b0;
        tick();
        check("rmid_ready_after", req_ready_o, 1'b1);
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= apu_req_o;
        end
        check("rmid_queue_flushed", seen, 1'b0);
        check("rmid_busy_after", busy_o, 1'b0);

        // Returned ID differs from the issued one
        push(6'h06, 4'd2, 1'b1);
        tick();
        check("idc_req", apu_req_o, 1'b1);
        apu_gnt_i = 1'b1;
        tick();
        apu_gnt_i = 1'b0;
        tick();
        apu_rvalid_i = 1'b1; apu_result_i = 32'hDEADBEEF; instruction_id_i = 4'd7;
        tick();
        apu_rvalid_i = 1'b0;
        check("idc_rsp_valid", rsp_valid_o, 1'b1);
        check("idc_rsp_result", rsp_result_o, 32'hDEADBEEF);
        check("idc_rsp_id", rsp_id_o, 4'd7);
        check("idc_id_err", id_err_o, ID_CHK);
        repeat (3) tick();
        check("idc_id_err_sticky", id_err_o, ID_CHK);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("idc_id_err_cleared", id_err_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
